// File: rtl/shift_deser_pkg.sv
// rtl/shift_deser_pkg.sv - shared types and constants for the serial deserializer
package shift_deser_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/deser_shift_core.sv
// rtl/deser_shift_core.sv - bidirectional insert-at-end shift register for frame assembly
module deser_shift_core
    import shift_deser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             insert,
    input  logic             restart,
    input  logic             dir,
    input  logic             sdi,
    output logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] next_value
);

    logic [WIDTH-1:0] base;

    // Next contents: a restart discards the old bits so the new bit becomes bit 1 of a frame
    always_comb begin
        base = restart ? '0 : value;
        if (dir == DIR_LSB_FIRST) begin
            next_value = {sdi, base[WIDTH-1:1]};
        end else begin
            next_value = {base[WIDTH-2:0], sdi};
        end
    end

    // Register update on every accepted bit
    always_ff @(posedge clk) begin
        if (clr) begin
            value <= '0;
        end else if (insert || restart) begin
            value <= next_value;
        end
    end

endmodule

// File: rtl/shift_deser8.sv
// rtl/shift_deser8.sv - serial-to-parallel frame receiver with double-buffered valid/ready output
module shift_deser8
    import shift_deser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             CLR,
    input  logic             SDI,
    input  logic             SEN,
    input  logic             FS,
    input  logic             DIR,
    input  logic             ERRCLR,
    output logic [WIDTH-1:0] Q,
    output logic             QV,
    input  logic             QR,
    output logic [CW-1:0]    CNT,
    output logic             BUSY,
    output logic             OVR,
    output logic             FERR
);

    state_t           state;
    state_t           state_nxt;
    logic             dir_q;
    logic             restart;
    logic             insert;
    logic             last_bit;
    logic             ferr_set;
    logic             ovr_set;
    logic             core_dir;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] word_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (CLR) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a frame sync always (re)starts a frame, the final bit returns to idle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (restart) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (restart)       state_nxt = SHIFT;
                else if (last_bit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Decoded strobes for the datapath and status
    always_comb begin
        BUSY     = (state == SHIFT);
        restart  = SEN && FS;
        insert   = SEN && !FS && (state == SHIFT);
        last_bit = insert && (CNT == CW'(WIDTH - 1));
        ferr_set = SEN && FS && (state == SHIFT) && (CNT != '0);
        ovr_set  = last_bit && QV && !QR;
    end

    // The frame-sync bit uses the live DIR; every later bit follows the latched direction
    assign core_dir = restart ? DIR : dir_q;

    deser_shift_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk       (clk),
        .clr       (CLR),
        .insert    (insert),
        .restart   (restart),
        .dir       (core_dir),
        .sdi       (SDI),
        .value     (shreg),
        .next_value(word_nxt)
    );

    // Bit counter and direction latch
    always_ff @(posedge clk) begin
        if (CLR) begin
            CNT   <= '0;
            dir_q <= DIR_MSB_FIRST;
        end else if (restart) begin
            CNT   <= CW'(1);
            dir_q <= DIR;
        end else if (last_bit) begin
            CNT <= '0;
        end else if (insert) begin
            CNT <= CNT + CW'(1);
        end
    end

    // Output buffer: take a completed word when the slot is free or being drained this edge
    always_ff @(posedge clk) begin
        if (CLR) begin
            Q  <= '0;
            QV <= 1'b0;
        end else if (last_bit && (!QV || QR)) begin
            Q  <= word_nxt;
            QV <= 1'b1;
        end else if (QV && QR) begin
            QV <= 1'b0;
        end
    end

    // Sticky error flags; a new error on the clearing edge wins
    always_ff @(posedge clk) begin
        if (CLR) begin
            OVR  <= 1'b0;
            FERR <= 1'b0;
        end else begin
            OVR  <= ovr_set  | (OVR  & ~ERRCLR);
            FERR <= ferr_set | (FERR & ~ERRCLR);
        end
    end

endmodule

// File: tb/tb_shift_deser8.sv
// tb/tb_shift_deser8.sv - self-checking bench for shift_deser8
module tb_shift_deser8;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          CLR = 1'b1;
    logic          SDI = 1'b0;
    logic          SEN = 1'b0;
    logic          FS = 1'b0;
    logic          DIR = 1'b0;
    logic          ERRCLR = 1'b0;
    logic          QR = 1'b0;
    logic [W-1:0]  Q;
    logic          QV;
    logic [CW-1:0] CNT;
    logic          BUSY;
    logic          OVR;
    logic          FERR;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    logic [W-1:0] m_bits = '0;
    int           m_cnt = 0;
    logic         m_busy = 1'b0;
    logic         m_dir = 1'b0;
    logic [W-1:0] m_q = '0;
    logic         m_qv = 1'b0;
    logic         m_ovr = 1'b0;
    logic         m_ferr = 1'b0;

    shift_deser8 dut (
        .clk   (clk),
        .CLR   (CLR),
        .SDI   (SDI),
        .SEN   (SEN),
        .FS    (FS),
        .DIR   (DIR),
        .ERRCLR(ERRCLR),
        .Q     (Q),
        .QV    (QV),
        .QR    (QR),
        .CNT   (CNT),
        .BUSY  (BUSY),
        .OVR   (OVR),
        .FERR  (FERR)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: keep the list of received bits, place them by direction when the frame is full
    always @(posedge clk) begin : model
        logic [W-1:0] b, word, qq;
        int c;
        logic bz, d, qv, ov, fe, done, ov_s, fe_s;
        b = m_bits; c = m_cnt; bz = m_busy; d = m_dir;
        qq = m_q; qv = m_qv; ov = m_ovr; fe = m_ferr;
        done = 1'b0; ov_s = 1'b0; fe_s = 1'b0; word = '0;
        if (CLR) begin
            b = '0; c = 0; bz = 1'b0; d = 1'b0;
            qq = '0; qv = 1'b0; ov = 1'b0; fe = 1'b0;
        end else begin
            if (SEN && FS) begin
                if (bz && c != 0) fe_s = 1'b1;
                b = '0;
                b[0] = SDI;
                c = 1;
                d = DIR;
                bz = 1'b1;
            end else if (SEN && bz) begin
                b[c] = SDI;
                c++;
                if (c == W) begin
                    done = 1'b1;
                    for (int i = 0; i < W; i++) word[d ? i : W - 1 - i] = b[i];
                    c = 0;
                    bz = 1'b0;
                end
            end
            if (done) begin
                if (!qv || QR) begin
                    qq = word;
                    qv = 1'b1;
                end else begin
                    ov_s = 1'b1;
                end
            end else if (qv && QR) begin
                qv = 1'b0;
            end
            if (ERRCLR) begin
                ov = 1'b0;
                fe = 1'b0;
            end
            ov = ov | ov_s;
            fe = fe | fe_s;
        end
        m_bits <= b; m_cnt <= c; m_busy <= bz; m_dir <= d;
        m_q <= qq; m_qv <= qv; m_ovr <= ov; m_ferr <= fe;
    end

    // Every-cycle comparison against the reference
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_q", 32'(Q), 32'(m_q));
            check("model_qv", 32'(QV), 32'(m_qv));
            check("model_cnt", 32'(CNT), m_cnt);
            check("model_busy", 32'(BUSY), 32'(m_busy));
            check("model_ovr", 32'(OVR), 32'(m_ovr));
            check("model_ferr", 32'(FERR), 32'(m_ferr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_bit(input logic b, input logic f, input logic d);
        SEN = 1'b1; SDI = b; FS = f; DIR = d;
        tick();
        SEN = 1'b0; FS = 1'b0;
    endtask

    task automatic send_bits(input logic [W-1:0] w, input logic d, input int first, input int last, input int gap);
        for (int i = first; i <= last; i++) begin
            put_bit(d ? w[i] : w[W - 1 - i], i == 0, d);
            if (i < last) repeat (gap) tick();
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_q"}, 32'(Q), 0);
        check({tag, "_qv"}, 32'(QV), 0);
        check({tag, "_cnt"}, 32'(CNT), 0);
        check({tag, "_busy"}, 32'(BUSY), 0);
        check({tag, "_ovr"}, 32'(OVR), 0);
        check({tag, "_ferr"}, 32'(FERR), 0);
    endtask

    initial begin
        logic [W-1:0] stream;
        int qr_pct;
        CLR = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        CLR = 1'b0;
        check_outputs_zero("reset");

        // MSB-first 1,0,1,1,0,0,1,0
        QR = 1'b1;
        send_bits(8'hB2, 1'b0, 0, W - 1, 0);
        check("msb_q", 32'(Q), 32'hB2);
        check("msb_qv", 32'(QV), 1);
        tick();
        check("msb_qv_drop", 32'(QV), 0);

        // LSB-first, same stream, DIR flipped mid-frame
        stream = 8'hB2;
        for (int i = 0; i < W; i++) put_bit(stream[W - 1 - i], i == 0, i < 3);
        check("lsb_q", 32'(Q), 32'h4D);
        tick();

        // Gapped with backpressure, then overrun and clear
        QR = 1'b0;
        send_bits(8'hA5, 1'b0, 0, W - 1, 3);
        check("gap_q", 32'(Q), 32'hA5);
        check("gap_qv", 32'(QV), 1);
        send_bits(8'h3C, 1'b0, 0, W - 1, 0);
        check("ovr_q_held", 32'(Q), 32'hA5);
        check("ovr_set", 32'(OVR), 1);
        ERRCLR = 1'b1;
        tick();
        ERRCLR = 1'b0;
        check("ovr_clr", 32'(OVR), 0);

        // Completion on the same edge as a handshake
        QR = 1'b1;
        tick();
        QR = 1'b0;
        send_bits(8'h11, 1'b0, 0, W - 1, 0);
        check("hold_q", 32'(Q), 32'h11);
        send_bits(8'h22, 1'b0, 0, W - 2, 0);
        QR = 1'b1;
        send_bits(8'h22, 1'b0, W - 1, W - 1, 0);
        check("simul_q", 32'(Q), 32'h22);
        check("simul_qv", 32'(QV), 1);
        check("simul_ovr", 32'(OVR), 0);
        tick();

        // Resync after 5 bits
        send_bits(8'hFF, 1'b0, 0, 4, 0);
        check("resync_cnt5", 32'(CNT), 5);
        send_bits(8'h5A, 1'b0, 0, 0, 0);
        check("resync_ferr", 32'(FERR), 1);
        check("resync_cnt1", 32'(CNT), 1);
        send_bits(8'h5A, 1'b0, 1, W - 1, 0);
        check("resync_q", 32'(Q), 32'h5A);
        ERRCLR = 1'b1;
        tick();
        ERRCLR = 1'b0;
        check("ferr_clr", 32'(FERR), 0);

        // Reset mid-frame with a word pending
        QR = 1'b0;
        send_bits(8'hC3, 1'b1, 0, W - 1, 0);
        check("pre_rst_q", 32'(Q), 32'hC3);
        send_bits(8'h77, 1'b0, 0, 3, 0);
        check("pre_rst_cnt", 32'(CNT), 4);
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        check_outputs_zero("midrst");
        for (int i = 0; i < 4; i++) put_bit(1'b1, 1'b0, 1'b0);
        check("nofs_cnt", 32'(CNT), 0);
        check("nofs_busy", 32'(BUSY), 0);
        check("nofs_qv", 32'(QV), 0);

        // Randomized traffic against the reference
        for (int i = 0; i < 4000; i++) begin
            qr_pct = ((i / 500) % 3 == 0) ? 90 : (((i / 500) % 3 == 1) ? 20 : 55);
            SEN = ($urandom_range(0, 3) != 0);
            FS = ($urandom_range(0, 11) == 0);
            SDI = 1'($urandom);
            DIR = 1'($urandom);
            QR = ($urandom_range(0, 99) < qr_pct);
            ERRCLR = ($urandom_range(0, 19) == 0);
            CLR = ($urandom_range(0, 299) == 0);
            tick();
        end
        SEN = 1'b0; FS = 1'b0; CLR = 1'b0; ERRCLR = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_deser8.md
Name: shift_deser8

Overview:
- Receive-side partner of the 8-bit universal shift register.
- Accepts the serial bitstream that the register shifts out, in either direction, and reassembles each WIDTH-bit frame into a parallel word.
- Presents the word to a downstream consumer through a valid/ready handshake.
- Frames are marked by a frame-sync strobe on their first bit.
- Output is double-buffered, so reception continues while a word waits to be consumed.

Parameters:
- WIDTH, 8, bits per frame and width of Q; must be at least 2.
- CW, $clog2(WIDTH+1), width of the CNT bit-counter output.

Ports:
- clk  input  1  rising-edge clock.
- CLR  input  1  synchronous, active-high reset.
- SDI  input  1  serial data bit; sampled only when SEN=1.
- SEN  input  1  bit strobe; one bit is taken per clk edge with SEN=1.
- FS  input  1  frame sync; qualified by SEN; marks the current SDI bit as bit 1 of a new frame.
- DIR  input  1  0 = MSB-first (first bit lands in Q[WIDTH-1]); 1 = LSB-first (first bit lands in Q[0]); sampled only on the FS bit.
- ERRCLR  input  1  clears the sticky OVR and FERR flags.
- Q  output  WIDTH  received word.
- QV  output  1  Q valid.
- QR  input  1  consumer ready; a transfer occurs on any edge where QV=1 and QR=1.
- CNT  output  CW  number of bits collected in the current frame (0..WIDTH-1).
- BUSY  output  1  high while in SHIFT.
- OVR  output  1  sticky overrun flag.
- FERR  output  1  sticky framing-error flag.

Behaviour:
- Reset: the clock and reset are fixed as one clock, `clk`, with synchronous active-high reset `CLR`.
- On CLR=1 at an edge:
  - state goes to IDLE;
  - shift register, Q, QV, CNT, BUSY, OVR and FERR all go to 0;
  - the latched direction goes to 0.
  - CLR has priority over every other input, including mid-frame, where the partial frame is discarded.
- State IDLE:
  - SEN=1, FS=0: bit ignored, no flag set.
  - SEN=1, FS=1: latch DIR, store SDI as bit 1, CNT←1, go to SHIFT.
- State SHIFT, on each SEN=1 edge:
  - DIR=0: shift-left insertion at the LSB (shreg←{shreg[WIDTH-2:0],SDI}).
  - DIR=1: shift-right insertion at the MSB (shreg←{SDI,shreg[WIDTH-1:1]}).
  - After that bit is inserted, CNT increments.
  - SEN=0 holds all state; gaps of any length are allowed.
- Frame completion: when the WIDTH-th bit is sampled, the assembled word is offered to the output buffer on that same edge.
  - CNT←0.
  - Next state is IDLE, or SHIFT restarted if the next frame's FS arrives later; no back-to-back bypass is needed.
- Latency: Q and QV=1 are visible in the cycle after the edge that sampled the last bit.
- Output buffer: the completed word is loaded into Q and QV←1 if QV=0 or QR=1 on that edge.
  - Otherwise the word is dropped, Q is unchanged, and OVR←1.
- Handshake:
  - QV=1 and QR=1 with no completion on that edge: QV←0.
  - A completion and a handshake on the same edge: load the new word and keep QV=1.
  - Q must be stable while QV=1 and QR=0.
  - QV must not depend combinationally on QR.
- Framing error: FS=1 with SEN=1 while in SHIFT and CNT≠0 means the partial frame is abandoned:
  - FERR←1;
  - the current bit becomes bit 1 of a new frame;
  - DIR is re-latched.
- Direction: changes on DIR outside the FS bit have no effect.
- ERRCLR:
  - Clears OVR and FERR at the edge.
  - If a new error occurs on the same edge, the set wins.
- Width rules:
  - CNT never reaches WIDTH; it wraps to 0 at completion.
  - Insertion order is fixed by DIR, so after WIDTH bits the first-received bit always sits at the end selected by DIR.

Decomposition:
- Package shift_deser_pkg holds:
  - state enum {IDLE, SHIFT};
  - direction constants DIR_MSB_FIRST=1'b0 and DIR_LSB_FIRST=1'b1;
  - default WIDTH.
- One sub-module, deser_shift_core. It is the bidirectional shift register:
  - inputs: insert-enable, direction, serial bit, restart;
  - output: the WIDTH-bit parallel value.
- The top level holds the FSM, counter, output buffer, handshake and flags.

Test Plan:
- MSB-first: FS+SEN on bit 1 with DIR=0, then stream 1,0,1,1,0,0,1,0 on consecutive SEN edges with QR=1 → Q=8'hB2, QV=1 one cycle after the 8th bit, dropping after one handshake.
- LSB-first: same stream with DIR=1 → Q=8'h4D; set DIR=0 at bit 4 mid-frame → still 8'h4D.
- Gapped and backpressured: stream 8'hA5 with SEN idle 3 cycles between bits and QR=0 → Q=8'hA5 held, QV=1. Then send a second frame 8'h3C with QR still 0 → Q stays 8'hA5 and OVR=1. Pulse ERRCLR → OVR=0.
- Simultaneous completion and handshake: QV=1 holding 8'h11; the last bit of 8'h22 arrives on the same edge as QR=1 → Q=8'h22, QV stays 1, OVR=0.
- Resync: FS after 5 bits → FERR=1, CNT=1. The following 7 bits complete a new frame whose value matches the expected word from the FS bit onward.
- Reset: assert CLR at CNT=4 with QV=1 → all outputs 0 next cycle. Bits without FS afterwards → no capture, CNT stays 0.
